morph_window_gen: RTL and testbench

Raster-to-window converter that feeds the morphological operator kernel. It accepts one pixel per valid cycle in raster order and buffers the previous OPERATOR_SIZE-1 lines. For every input pixel whose full OPERATOR_SIZE×OPERATOR_SIZE neighbourhood lies inside the image, it emits the packed window in the exact bus format the kernel's `in_data`/`in_valid` ports consume. It sits between the video input stream and the morphological kernel.

---
 rtl/morph_window_gen.sv | 124 ++++++++++++
 tb/tb_morph_window_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_window_gen.sv
// Raster pixel stream to packed OPERATOR_SIZE x OPERATOR_SIZE windows for the morphological kernel.
// Cascaded per-column line buffers feed a window register; the packed output is a second stage.
module morph_window_gen #(
  parameter int unsigned VIDEO_DATA_WIDTH = 8,
  parameter int unsigned OPERATOR_SIZE    = 3,
  parameter int unsigned IMG_WIDTH        = 640,
  parameter int unsigned IMG_HEIGHT       = 480
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [VIDEO_DATA_WIDTH-1:0]                            in_data,
  input  logic                                                   in_valid,
  input  logic                                                   in_sof,
  output logic [OPERATOR_SIZE*OPERATOR_SIZE*VIDEO_DATA_WIDTH-1:0] out_data,
  output logic                                                   out_valid
);

  localparam int unsigned N      = OPERATOR_SIZE;
  localparam int unsigned Lb     = N - 1;
  localparam int unsigned OutW   = N * N * VIDEO_DATA_WIDTH;
  localparam int unsigned ColW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_HEIGHT - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(N - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(N - 1);

  typedef logic [VIDEO_DATA_WIDTH-1:0] pix_t;

  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;
  pix_t            lb_q  [Lb][IMG_WIDTH];
  pix_t            lb_rd [Lb];
  pix_t            win_q [N][N];
  pix_t            win_d [N][N];
  logic            emit;
  logic            valid1_q;
  logic            out_valid_q;
  logic [OutW-1:0] out_data_q, out_data_d;

  // Position of the pixel on the input bus; in_sof overrides the counters.
  always_comb begin
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < Lb; k++) begin
      lb_rd[k] = lb_q[k][cur_col];
    end
  end

  // Shift left; new right column is oldest line at the top, current pixel at the bottom.
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < N - 1; r++) begin
        win_d[r][N-1] = lb_rd[Lb-1-r];
      end
      win_d[N-1][N-1] = in_data;
    end
  end

  assign emit = in_valid && (cur_row >= RowFirst) && (cur_col >= ColFirst);

  always_comb begin
    out_data_d = out_data_q;
    if (valid1_q) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          out_data_d[(r*N+c)*VIDEO_DATA_WIDTH +: VIDEO_DATA_WIDTH] = win_q[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '{default: '0};
      valid1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      valid1_q    <= emit;
      out_valid_q <= valid1_q;
      out_data_q  <= out_data_d;
    end
  end

  // Line buffer contents are deliberately not reset; the row gate hides stale lines.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_q[0][cur_col] <= in_data;
      for (int k = 1; k < Lb; k++) begin
        lb_q[k][cur_col] <= lb_rd[k-1];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_morph_window_gen.sv
// Bench for morph_window_gen: a 3x3/4x4 instance and a 5x5/8x6 instance checked against
// a position-based image model every cycle, plus literal window checks.
module tb_morph_window_gen;

  typedef struct {
    time            due;
    logic [199:0]   win;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   d0, d1;
  logic         v0, s0, v1, s1;
  logic [71:0]  od0;
  logic [199:0] od1;
  logic         ov0, ov1;

  int           total = 0;
  int           bad   = 0;
  int           nn [2] = '{3, 5};
  int           ww [2] = '{4, 8};
  int           hh [2] = '{4, 6};
  int           img [2][6][8];
  int           mrow [2];
  int           mcol [2];
  int           cnt [2] = '{0, 0};
  logic [199:0] last [2];
  exp_t         q0[$], q1[$];
  logic [199:0] mq0[$];
  logic [199:0] cap0[$], cap1[$];

  always #5 clk = ~clk;

  morph_window_gen #(
    .VIDEO_DATA_WIDTH(8), .OPERATOR_SIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_sof(s0),
    .out_data(od0), .out_valid(ov0)
  );

  morph_window_gen #(
    .VIDEO_DATA_WIDTH(8), .OPERATOR_SIZE(5), .IMG_WIDTH(8), .IMG_HEIGHT(6)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_sof(s1),
    .out_data(od1), .out_valid(ov1)
  );

  function automatic void chk(input string name, input logic [199:0] act,
                              input logic [199:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [199:0] lit9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    int t[9];
    logic [199:0] w;
    t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(t[i]);
    return w;
  endfunction

  // Model: place each pixel in an image at its raster position; a window is the
  // N x N block ending at the current pixel, due at the negedge 1.5 cycles after acceptance.
  task automatic model_pixel(input int i, input int data, input bit sof);
    int r, c, n;
    logic [199:0] w;
    exp_t e;
    if (sof) begin
      mrow[i] = 0;
      mcol[i] = 0;
    end
    r = mrow[i];
    c = mcol[i];
    n = nn[i];
    img[i][r][c] = data;
    if (r >= n - 1 && c >= n - 1) begin
      w = '0;
      for (int a = 0; a < n; a++)
        for (int b = 0; b < n; b++)
          w[(a*n+b)*8 +: 8] = 8'(img[i][r-n+1+a][c-n+1+b]);
      e.due = $time + 15;
      e.win = w;
      if (i == 0) begin
        q0.push_back(e);
        mq0.push_back(w);
      end else begin
        q1.push_back(e);
      end
    end
    mcol[i] = c + 1;
    if (mcol[i] == ww[i]) begin
      mcol[i] = 0;
      mrow[i] = r + 1;
      if (mrow[i] == hh[i]) mrow[i] = 0;
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q0.delete();
        q1.delete();
        mrow = '{0, 0};
        mcol = '{0, 0};
      end else begin
        if (v0) model_pixel(0, int'(d0), s0);
        if (v1) model_pixel(1, int'(d1), s1);
      end
    end
  endtask

  task automatic mon_inst(input int i, input logic ov, input logic [199:0] od);
    exp_t e;
    bit   ev;
    ev = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].due == $time) begin
        ev = 1'b1;
        e  = q0.pop_front();
      end
    end else begin
      if (q1.size() > 0 && q1[0].due == $time) begin
        ev = 1'b1;
        e  = q1.pop_front();
      end
    end
    chk($sformatf("out_valid%0d", i), {199'b0, ov}, {199'b0, ev});
    if (ov === 1'b1 && ev) chk($sformatf("window%0d", i), od, e.win);
    if (ov !== 1'b1) chk($sformatf("hold%0d", i), od, last[i]);
    if (ov === 1'b1) begin
      last[i] = od;
      cnt[i]++;
      if (i == 0) cap0.push_back(od);
      else cap1.push_back(od);
    end
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        last[0] = '0;
        last[1] = '0;
      end else begin
        mon_inst(0, ov0, {128'b0, od0});
        mon_inst(1, ov1, od1);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int i, input int val, input bit sof);
    if (i == 0) begin
      d0 = 8'(val);
      v0 = 1'b1;
      s0 = sof;
    end else begin
      d1 = 8'(val);
      v1 = 1'b1;
      s1 = sof;
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
    s0 = 1'b0;
    v1 = 1'b0;
    s1 = 1'b0;
  endtask

  task automatic send_frame(input int i, input int base, input int gap_max);
    for (int r = 0; r < hh[i]; r++) begin
      for (int c = 0; c < ww[i]; c++) begin
        drive_pix(i, base + r * ww[i] + c, (r == 0 && c == 0));
        if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
      end
    end
  endtask

  int s;

  initial begin
    rst = 1'b1;
    d0 = '0; v0 = 1'b0; s0 = 1'b0;
    d1 = '0; v1 = 1'b0; s1 = 1'b0;
    last = '{default: '0};
    fork
      model_loop();
      mon_loop();
    join_none
    idle(2);
    chk("rst_out_valid0", {199'b0, ov0}, '0);
    chk("rst_out_data0", {128'b0, od0}, '0);
    chk("rst_out_valid1", {199'b0, ov1}, '0);
    chk("rst_out_data1", od1, '0);
    rst = 1'b0;
    idle(1);

    // Streaming frame
    s = cnt[0];
    send_frame(0, 0, 0);
    idle(4);
    chk("stream_count", 200'(cnt[0] - s), 200'd4);
    chk("stream_first", cap0[s], lit9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("stream_last", cap0[s+3], lit9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    chk("model_first", mq0[s], lit9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("model_last", mq0[s+3], lit9(5, 6, 7, 9, 10, 11, 13, 14, 15));

    // Gapped input
    s = cnt[0];
    send_frame(0, 0, 5);
    idle(4);
    chk("gap_count", 200'(cnt[0] - s), 200'd4);
    chk("gap_first", cap0[s], lit9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("gap_last", cap0[s+3], lit9(5, 6, 7, 9, 10, 11, 13, 14, 15));

    // Back-to-back frames
    s = cnt[0];
    send_frame(0, 0, 0);
    send_frame(0, 100, 0);
    idle(4);
    chk("b2b_count", 200'(cnt[0] - s), 200'd8);
    chk("b2b_second_first", cap0[s+4], lit9(100, 101, 102, 104, 105, 106, 108, 109, 110));
    chk("b2b_second_last", cap0[s+7], lit9(105, 106, 107, 109, 110, 111, 113, 114, 115));

    // Mid-frame resync at pixel 6
    s = cnt[0];
    for (int k = 0; k < 6; k++) drive_pix(0, k, (k == 0));
    send_frame(0, 0, 0);
    idle(4);
    chk("resync_count", 200'(cnt[0] - s), 200'd4);
    chk("resync_first", cap0[s], lit9(0, 1, 2, 4, 5, 6, 8, 9, 10));

    // Asynchronous reset pulse just after pixel 10 is accepted
    s = cnt[0];
    for (int k = 0; k < 11; k++) drive_pix(0, k, (k == 0));
    d0 = 8'd11;
    v0 = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {199'b0, ov0}, '0);
    chk("midrst_out_data", {128'b0, od0}, '0);
    #9;
    rst = 1'b0;
    v0  = 1'b0;
    idle(3);
    chk("midrst_dropped", 200'(cnt[0] - s), 200'd0);
    s = cnt[0];
    send_frame(0, 0, 0);
    idle(4);
    chk("postrst_count", 200'(cnt[0] - s), 200'd4);
    chk("postrst_first", cap0[s], lit9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("postrst_last", cap0[s+3], lit9(5, 6, 7, 9, 10, 11, 13, 14, 15));

    // Parameter sweep: 5x5 operator on 8x6 image
    s = cnt[1];
    send_frame(1, 0, 0);
    idle(4);
    chk("sweep_count", 200'(cnt[1] - s), 200'd8);
    chk("sweep_e24", 200'(cap1[s][199:192]), 200'd36);
    chk("sweep_e0", 200'(cap1[s][7:0]), 200'd0);
    chk("sweep_last_e24", 200'(cap1[s+7][199:192]), 200'd47);

    chk("queue0_drained", 200'(q0.size()), 200'd0);
    chk("queue1_drained", 200'(q1.size()), 200'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
